// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive blocks.
// Holds the frame state encoding, the data width and the bit-period helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Bit period in core clocks, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO with registered full flag and level output.
// Shared by the UART transmit and receive paths.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      level_d = level_q + (AW + 1)'(1);
    end else if (pop_ok && !push_ok) begin
      level_d = level_q - (AW + 1)'(1);
    end
    full_d = (level_d == (AW + 1)'(DEPTH));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: FIFO-fed frame FSM, baud down-counter and shift register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a queued byte
// ST_START  | start bit (low) for one bit period
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | even parity bit (UART_TX_PARITY_EN only)
// ST_STOP   | stop bit (high); chains straight into the next frame if a byte is queued
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK_100MHZ,
  input  logic                          RESET,
  input  logic [DATA_W-1:0]             TX_DATA,
  input  logic                          TX_VALID,
  output logic                          TX_READY,
  output logic                          TX,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(DIV);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, line_d;
  logic              tick;
  logic              pop;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_full;
  logic              fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk_i   (CLK_100MHZ),
    .rst_i   (RESET),
    .push_i  (TX_VALID),
    .data_i  (TX_DATA),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (FIFO_LEVEL)
  );

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != ST_IDLE) begin
      cnt_d = tick ? CNT_W'(DIV - 1) : cnt_q - CNT_W'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop always launches a new frame from the FIFO head.
    if (pop) begin
      shift_d = fifo_data;
      state_d = ST_START;
      cnt_d   = CNT_W'(DIV - 1);
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_data;
`endif
    end
  end

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_d = par_q;
`endif
      default:   line_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK_100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= line_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign TX       = tx_q;
  assign TX_READY = !fifo_full;
  assign BUSY     = (state_q != ST_IDLE) || (FIFO_LEVEL != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: DIV=10, FIFO_DEPTH=4.
// A line monitor decodes frames and compares them against queued expected bytes.
module tb_uart_tx_buffered;

  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * DIV;

  logic       clk;
  logic       RESET;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       TX;
  logic       BUSY;
  logic [2:0] FIFO_LEVEL;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int frames  = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  uart_tx_buffered #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .CLK_100MHZ (clk),
    .RESET      (RESET),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .TX         (TX),
    .BUSY       (BUSY),
    .FIFO_LEVEL (FIFO_LEVEL)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one byte for the next edge; acc is whether the bench expects it to be taken.
  task automatic push(input logic [7:0] b, input logic acc, output int edge_n);
    @(negedge clk);
    TX_DATA  = b;
    TX_VALID = 1'b1;
    chk("ready_at_push", TX_READY, acc);
    if (acc) exp_q.push_back(b);
    edge_n = cyc + 1;
  endtask

  task automatic release_valid();
    @(negedge clk);
    TX_VALID = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (BUSY && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("idle_within_budget", BUSY, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  // Line monitor: mid-bit sampling, aborted by reset.
  initial begin : monitor
    int   mcnt;
    int   k;
    logic active;
    logic [7:0] mbyte;
    logic [7:0] e;
    active = 1'b0;
    mcnt   = 0;
    mbyte  = '0;
    forever begin
      @(negedge clk);
      if (RESET) begin
        active = 1'b0;
      end else if (!active) begin
        if (TX === 1'b0) begin
          active = 1'b1;
          mcnt   = 0;
          mbyte  = '0;
          starts.push_back(cyc);
        end
      end else begin
        mcnt++;
        if (mcnt % DIV == DIV / 2) begin
          k = mcnt / DIV;
          if (k == 0) begin
            chk("start_bit", TX, 1'b0);
          end else if (k <= 8) begin
            mbyte[k-1] = TX;
          end else if (k == FRAME_BITS - 1) begin
            chk("stop_bit", TX, 1'b1);
            chk("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              chk("rx_byte", mbyte, e);
            end
            frames++;
          end else begin
            chk("parity_bit", TX, ^mbyte);
          end
        end
        if (mcnt == FRAME - 1) active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int dummy;
    int base;
    int f0;
    RESET    = 1'b1;
    TX_VALID = 1'b0;
    TX_DATA  = '0;
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    chk("rst_tx", TX, 1'b1);
    chk("rst_ready", TX_READY, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_level", FIFO_LEVEL, 3'd0);

    // Single byte: start edge at N+2, BUSY drops one frame after the pop.
    push(8'h55, 1'b1, n);
    release_valid();
    chk("lat_n0_tx", TX, 1'b1);
    @(negedge clk);
    chk("lat_n1_tx", TX, 1'b1);
    @(negedge clk);
    chk("lat_n2_tx", TX, 1'b0);
    wait_cyc(n + FRAME);
    chk("busy_last", BUSY, 1'b1);
    @(negedge clk);
    chk("busy_drop", BUSY, 1'b0);
    wait_idle(50);

    // Back-to-back frames with no idle gap.
    base = starts.size();
    push(8'h00, 1'b1, n);
    push(8'hFF, 1'b1, dummy);
    release_valid();
    wait_idle(3 * FRAME);
    chk("b2b_frames", starts.size() - base, 2);
    if (starts.size() >= base + 2) chk("b2b_gap", starts[base+1] - starts[base], FRAME);

    // Fill to full; the sixth byte must be refused and never appear.
    f0 = frames;
    push(8'h11, 1'b1, n);
    push(8'h22, 1'b1, dummy);
    push(8'h33, 1'b1, dummy);
    push(8'h44, 1'b1, dummy);
    push(8'h5A, 1'b1, dummy);
    push(8'h66, 1'b0, dummy);
    release_valid();
    chk("full_ready", TX_READY, 1'b0);
    chk("full_level", FIFO_LEVEL, 3'd4);
    wait_idle(6 * FRAME);
    chk("full_frames", frames - f0, 5);
    chk("full_drained", exp_q.size(), 0);

    // Reset during data bit 3 of 0xC3 (bit 3 = 0), with 0x3C still queued.
    f0 = frames;
    push(8'hC3, 1'b1, n);
    push(8'h3C, 1'b1, dummy);
    release_valid();
    wait_cyc(n + 2 + 3 * DIV + DIV / 2 + DIV);
    chk("pre_rst_tx", TX, 1'b0);
    chk("pre_rst_level", FIFO_LEVEL, 3'd1);
    RESET = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_tx", TX, 1'b1);
    chk("async_rst_level", FIFO_LEVEL, 3'd0);
    chk("async_rst_busy", BUSY, 1'b0);
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    repeat (2) @(negedge clk);
    push(8'hA5, 1'b1, dummy);
    release_valid();
    wait_idle(2 * FRAME);
    chk("post_rst_frames", frames - f0, 1);
    chk("post_rst_drained", exp_q.size(), 0);

    // Parity-relevant bytes back to back; gap checks full frame length.
    base = starts.size();
    push(8'h07, 1'b1, n);
    push(8'h03, 1'b1, dummy);
    release_valid();
    wait_idle(3 * FRAME);
    chk("par_frames", starts.size() - base, 2);
    if (starts.size() >= base + 2) chk("par_gap", starts[base+1] - starts[base], FRAME);
    chk("final_drained", exp_q.size(), 0);
    chk("final_tx", TX, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
